sigma1_unit: RTL and testbench
==============================

Name: sigma1_unit

Overview:
- Registered SHA-256 big-Sigma1 function: Y = ROTR6(A) ^ ROTR11(A) ^ ROTR25(A), with 32-bit words and bit 31 as the MSB.
- Used in the compression round datapath to compute the T1 term from working variable e.
- A combinational core is followed by one output register stage with a valid flag.

Parameters:
- WIDTH, 32, word width; fixed at 32. Any other value is unsupported and must trigger an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a for this cycle
- a  input  32  input word (e)
- out_valid  output  1  y holds a fresh result
- y  output  32  registered Sigma1 result
- (Optional, see below) sel_small  input  1  function select

Behaviour:
- Combinational core: f(a) = {a[5:0],a[31:6]} ^ {a[10:0],a[31:11]} ^ {a[24:0],a[31:25]}. Pure rotations only, no shifts.
- Reset: while rst_n = 0, out_valid = 0 and y = 32'h0. Both clear immediately and asynchronously. Release is sampled on the next rising clk.
- Latency: exactly 1 cycle. On a rising clk with in_valid = 1, y <= f(a) and out_valid <= 1.
- On a rising clk with in_valid = 0: out_valid <= 0 and y holds its previous value. No garbage is loaded.
- Throughput: one word per cycle. Back-to-back in_valid produces back-to-back out_valid.
- No backpressure: the output is not stalled, and the consumer must sample y in the out_valid cycle.
- Reset asserted mid-stream: the in-flight result is discarded, and out_valid = 0 on the first edge after release unless in_valid = 1 on that edge.
- Invariants to hold:
  - f(0) = 0 and f(FFFFFFFF) = FFFFFFFF (XOR of three equal words).
  - Any input whose period divides the rotation structure returns itself, e.g. CCCCCCCC and AAAAAAAA.
- No X propagation from a when in_valid = 0: the register is not enabled.

Optional Feature:
- Macro: SIGMA1_SMALL_EN.
- When defined:
  - Port sel_small is present.
  - sel_small = 1 selects SHA-256 small sigma1 instead: ROTR17(a) ^ ROTR19(a) ^ SHR10(a), where SHR shifts zeros into the MSBs.
  - sel_small is sampled together with a when in_valid = 1, with the same 1-cycle latency.
  - sel_small = 0 gives big Sigma1, identical to the base behaviour.
- When undefined:
  - The port is absent and only big Sigma1 is implemented.
  - No small-sigma logic is synthesised.

Decomposition:
- Shared package sha256_pkg:
  - word_t (32-bit logic) typedef.
  - Rotation/shift constants: BS1_R0 = 6, BS1_R1 = 11, BS1_R2 = 25; SS1_R0 = 17, SS1_R1 = 19, SS1_SH = 10.
  - Pure functions rotr(word, n) and shr(word, n).
- One sub-module: sigma1_core, purely combinational (a, optional sel_small -> f). It is reused by the message-schedule block.
- sigma1_unit adds only the valid/output register stage around sigma1_core.

Test Plan:
- Reset and passthrough:
  - Assert rst_n = 0 mid-run -> out_valid = 0 and y = 0 immediately.
  - After release with in_valid = 0 -> out_valid stays 0.
- Big Sigma1 vectors, one per cycle with in_valid = 1, each checked one cycle later with out_valid = 1:
  - FFFFFFFF -> FFFFFFFF
  - FFFF0000 -> FC60039F
  - F0F0F0F0 -> A5A5A5A5
  - CCCCCCCC -> CCCCCCCC
  - AAAAAAAA -> AAAAAAAA
  - 00000000 -> 00000000
- Valid gating: a = 12345678 with in_valid = 0 after a valid F0F0F0F0 -> y holds A5A5A5A5 and out_valid = 0.
- Back-to-back: in_valid held high for 5 cycles with the vectors above -> 5 consecutive out_valid pulses, with results in input order.
- Reset mid-operation: drive FFFF0000 with in_valid = 1 and pulse rst_n low before the edge -> out_valid = 0 and y = 0. Reissue after release -> FC60039F.
- SIGMA1_SMALL_EN build with sel_small = 1:
  - FFFFFFFF -> 003FFFFF
  - 00000000 -> 00000000
  - sel_small = 0 with F0F0F0F0 -> A5A5A5A5

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, rotation/shift constants and bit-manipulation helpers.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam int unsigned BS1_R0 = 6;
    localparam int unsigned BS1_R1 = 11;
    localparam int unsigned BS1_R2 = 25;
    localparam int unsigned SS1_R0 = 17;
    localparam int unsigned SS1_R1 = 19;
    localparam int unsigned SS1_SH = 10;

    function automatic word_t rotr(input word_t w, input int unsigned n);
        return (w >> n) | (w << (WORD_W - n));
    endfunction

    function automatic word_t shr(input word_t w, input int unsigned n);
        return w >> n;
    endfunction

endpackage

// File: rtl/sigma1_core.sv
// Combinational SHA-256 big Sigma1; small sigma1 is also available when
// SIGMA1_SMALL_EN is defined (selected by sel_small).
module sigma1_core
    import sha256_pkg::*;
(
    input  logic [31:0] a,
`ifdef SIGMA1_SMALL_EN
    input  logic        sel_small,
`endif
    output logic [31:0] f
);

    word_t big_sig;

    always_comb begin
        big_sig = rotr(a, BS1_R0) ^ rotr(a, BS1_R1) ^ rotr(a, BS1_R2);
    end

`ifdef SIGMA1_SMALL_EN
    word_t small_sig;

    always_comb begin
        small_sig = rotr(a, SS1_R0) ^ rotr(a, SS1_R1) ^ shr(a, SS1_SH);
        f         = sel_small ? small_sig : big_sig;
    end
`else
    always_comb begin
        f = big_sig;
    end
`endif

endmodule

// File: rtl/sigma1_unit.sv
// Registered Sigma1: sigma1_core followed by one output/valid register stage.
// Optional small-sigma1 select port enabled by SIGMA1_SMALL_EN.
module sigma1_unit
    import sha256_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
`ifdef SIGMA1_SMALL_EN
    input  logic        sel_small,
`endif
    output logic        out_valid,
    output logic [31:0] y
);

    if (WIDTH != WORD_W) begin : g_bad_width
        $error("sigma1_unit: WIDTH must be 32");
    end

    word_t f;
    word_t y_d, y_q;
    logic  out_valid_d, out_valid_q;

    sigma1_core u_core (
        .a         (a),
`ifdef SIGMA1_SMALL_EN
        .sel_small (sel_small),
`endif
        .f         (f)
    );

    // y only loads on a qualified word, so idle cycles never disturb it
    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sigma1_unit.sv
// Directed bench for sigma1_unit with an expected-result queue; covers the
// small-sigma1 select when SIGMA1_SMALL_EN is defined.
module tb_sigma1_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic        sel_small;
    logic        out_valid;
    logic [31:0] y;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_y;

    always #5 clk = ~clk;

    sigma1_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
`ifdef SIGMA1_SMALL_EN
        .sel_small (sel_small),
`endif
        .out_valid (out_valid),
        .y         (y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, then check the registered result one edge later.
    task automatic step(input logic v, input logic s, input logic [31:0] av, input logic [31:0] exp_y);
        logic [31:0] want;
        @(negedge clk);
        in_valid  = v;
        sel_small = s;
        a         = av;
        if (v) exp_q.push_back(exp_y);
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, v});
        if (v) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                chk("y", y, want);
                last_y = want;
            end
        end else begin
            chk("y_hold", y, last_y);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        sel_small = 1'b0;
        last_y    = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_y", y, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'hDEADBEEF, 32'h0);

        // back-to-back big Sigma1 vectors
        step(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 32'hFFFF0000, 32'hFC60039F);
        step(1'b1, 1'b0, 32'hF0F0F0F0, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 32'hCCCCCCCC, 32'hCCCCCCCC);
        step(1'b1, 1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA);
        step(1'b1, 1'b0, 32'h00000000, 32'h00000000);

        // valid gating: y must hold
        step(1'b1, 1'b0, 32'hF0F0F0F0, 32'hA5A5A5A5);
        step(1'b0, 1'b0, 32'h12345678, 32'h0);
        step(1'b0, 1'b0, 32'hFFFF0000, 32'h0);

        // reset mid-operation discards the in-flight word
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hFFFF0000;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_y", y, 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_edge_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_edge_y", y, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        last_y   = '0;
        step(1'b0, 1'b0, 32'hFFFF0000, 32'h0);
        step(1'b1, 1'b0, 32'hFFFF0000, 32'hFC60039F);
        step(1'b1, 1'b0, 32'h0F0F0F0F, 32'h5A5A5A5A);

`ifdef SIGMA1_SMALL_EN
        step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h003FFFFF);
        step(1'b1, 1'b1, 32'h00000000, 32'h00000000);
        step(1'b1, 1'b0, 32'hF0F0F0F0, 32'hA5A5A5A5);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0);
`endif

        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
